// File: rtl/keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : keypad_scan_ctrl
// Purpose : 4x4 keypad row scanner with press/release debounce; each accepted
//           key is shifted into a two-digit hex display register.
// Revision: 1.0 - initial release
// ============================================================================
module keypad_scan_ctrl #(
    parameter int SCAN_DIV     = 12000,
    parameter int DEBOUNCE_CNT = 960000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] columns,
    output logic [3:0] rows,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic [3:0] digit_new,
    output logic [3:0] digit_old
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(DEBOUNCE_CNT);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CNT - 1);

    localparam logic [1:0] ST_SCAN       = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE   = 2'd1;
    localparam logic [1:0] ST_HELD       = 2'd2;
    localparam logic [1:0] ST_RELEASE_DB = 2'd3;

    logic [3:0]    col_meta_q, col_s_q;
    logic [1:0]    state_q, state_d;
    logic [1:0]    row_idx_q, row_idx_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [BW-1:0] deb_q, deb_d;
    logic          key_valid_q, key_valid_d;
    logic [3:0]    key_code_q, key_code_d;
    logic [3:0]    digit_new_q, digit_new_d;
    logic [3:0]    digit_old_q, digit_old_d;

    logic [3:0]    w_col_low;
    logic          w_one_low;
    logic [1:0]    w_low_idx;
    logic          w_col_bit;
    logic          w_dwell_end;
    logic          w_deb_end;
    logic          w_advance;
    logic          w_accept;
    logic [3:0]    w_code;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [15:0] row_codes;
        case (r)
            2'd0:    row_codes = 16'hA321;
            2'd1:    row_codes = 16'hB654;
            2'd2:    row_codes = 16'hC987;
            default: row_codes = 16'hDF0E;
        endcase
        return row_codes[{c, 2'b00} +: 4];
    endfunction

    // A row is only accepted when exactly one column is pulled low.
    assign w_col_low   = ~col_s_q;
    assign w_one_low   = (w_col_low != 4'b0000) && ((w_col_low & (w_col_low - 4'd1)) == 4'b0000);
    assign w_col_bit   = col_s_q[col_idx_q];
    assign w_dwell_end = (dwell_q == DWELL_LAST);
    assign w_deb_end   = (deb_q == DEB_LAST);
    assign w_code      = key_map(row_idx_q, col_idx_q);

    always_comb begin
        w_low_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (w_col_low[i]) begin
                w_low_idx = 2'(i);
            end
        end
    end

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            col_meta_q  <= 4'b1111;
            col_s_q     <= 4'b1111;
            state_q     <= ST_SCAN;
            row_idx_q   <= 2'd0;
            col_idx_q   <= 2'd0;
            dwell_q     <= '0;
            deb_q       <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
            digit_new_q <= 4'h0;
            digit_old_q <= 4'h0;
        end else begin
            col_meta_q  <= columns;
            col_s_q     <= col_meta_q;
            state_q     <= state_d;
            row_idx_q   <= row_idx_d;
            col_idx_q   <= col_idx_d;
            dwell_q     <= dwell_d;
            deb_q       <= deb_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            digit_new_q <= digit_new_d;
            digit_old_q <= digit_old_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SCAN: begin
                if (w_dwell_end && w_one_low) begin
                    state_d = ST_DEBOUNCE;
                end
            end
            ST_DEBOUNCE: begin
                if (w_col_bit) begin
                    state_d = ST_SCAN;
                end else if (w_deb_end) begin
                    state_d = ST_HELD;
                end
            end
            ST_HELD: begin
                if (w_col_bit) begin
                    state_d = ST_RELEASE_DB;
                end
            end
            ST_RELEASE_DB: begin
                if (!w_col_bit) begin
                    state_d = ST_HELD;
                end else if (w_deb_end) begin
                    state_d = ST_SCAN;
                end
            end
            default: state_d = ST_SCAN;
        endcase
    end

    // Datapath and output logic, driven by the transition being taken
    always_comb begin
        w_advance = ((state_q == ST_SCAN) && w_dwell_end && !w_one_low)
                 || ((state_q != ST_SCAN) && (state_d == ST_SCAN));
        w_accept  = (state_q == ST_DEBOUNCE) && (state_d == ST_HELD);

        row_idx_d = w_advance ? (row_idx_q + 2'd1) : row_idx_q;
        col_idx_d = ((state_q == ST_SCAN) && (state_d == ST_DEBOUNCE)) ? w_low_idx : col_idx_q;

        dwell_d = dwell_q;
        if (state_d == ST_SCAN) begin
            dwell_d = ((state_q != ST_SCAN) || w_dwell_end) ? '0 : (dwell_q + DW'(1));
        end

        // Every entry into a debounce state starts the count from zero.
        deb_d = deb_q;
        if (state_d != state_q) begin
            deb_d = '0;
        end else if ((state_q == ST_DEBOUNCE) || (state_q == ST_RELEASE_DB)) begin
            deb_d = deb_q + BW'(1);
        end

        key_valid_d = w_accept;
        key_code_d  = w_accept ? w_code : key_code_q;
        digit_new_d = w_accept ? w_code : digit_new_q;
        digit_old_d = w_accept ? digit_new_q : digit_old_q;

        rows      = ~(4'b0001 << row_idx_q);
        key_valid = key_valid_q;
        key_code  = key_code_q;
        digit_new = digit_new_q;
        digit_old = digit_old_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_keypad_scan_ctrl
// Purpose : Testbench for keypad_scan_ctrl: physical keypad model, directed
//           scenarios and random presses checked against accepted keys.
// Revision: 1.1 - explicit comparisons
// ============================================================================
module tb_keypad_scan_ctrl;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 8;
    localparam int LAT          = 4 * SCAN_DIV + 2 + DEBOUNCE_CNT + 1 + 2;
    localparam int SETTLE       = DEBOUNCE_CNT + 6;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] columns;
    logic [3:0] rows;
    logic       key_valid;
    logic [3:0] key_code;
    logic [3:0] digit_new;
    logic [3:0] digit_old;

    logic [15:0] pressed;
    int checks = 0;
    int errors = 0;
    int pulses = 0;
    logic [11:0] prev_out;
    logic [3:0] accepted [$];

    logic [3:0] KEYMAP [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC,
                                4'hE, 4'h0, 4'hF, 4'hD};

    keypad_scan_ctrl #(
        .SCAN_DIV    (SCAN_DIV),
        .DEBOUNCE_CNT(DEBOUNCE_CNT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .columns  (columns),
        .rows     (rows),
        .key_valid(key_valid),
        .key_code (key_code),
        .digit_new(digit_new),
        .digit_old(digit_old)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input bit ok, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    always_comb begin
        columns = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4 + c] && !rows[r]) begin
                    columns[c] = 1'b0;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (key_valid === 1'b1) pulses++;
        if (!reset) begin
            chk("rows_one_low", $countones(~rows) === 1, $countones(~rows), 1);
            if (key_valid !== 1'b1) begin
                chk("outputs_stable", {key_code, digit_new, digit_old} === prev_out,
                    {key_code, digit_new, digit_old}, prev_out);
            end
        end
        prev_out = {key_code, digit_new, digit_old};
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed running, expected done");
        $fatal(1, "watchdog expired");
    end

    function automatic int key_pos(input logic [3:0] k);
        for (int i = 0; i < 16; i++) begin
            if (KEYMAP[i] == k) return i;
        end
        return 0;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_digits(input string tag);
        logic [3:0] exp_new;
        logic [3:0] exp_old;
        exp_new = (accepted.size() > 0) ? accepted[$] : 4'h0;
        exp_old = (accepted.size() > 1) ? accepted[accepted.size()-2] : 4'h0;
        chk({tag, " digit_new"}, digit_new === exp_new, digit_new, exp_new);
        chk({tag, " digit_old"}, digit_old === exp_old, digit_old, exp_old);
    endtask

    task automatic wait_accept(input string tag, input logic [3:0] exp_code);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < LAT) begin
            @(negedge clk);
            n++;
            seen = (key_valid === 1'b1);
        end
        chk({tag, " accepted_in_time"}, seen === 1'b1, seen, 1'b1);
        if (seen) begin
            accepted.push_back(exp_code);
            chk({tag, " key_code"}, key_code === exp_code, key_code, exp_code);
            check_digits(tag);
            @(negedge clk);
            chk({tag, " pulse_width"}, key_valid === 1'b0, key_valid, 1'b0);
        end
    endtask

    initial begin
        int         p;
        int         n;
        int         pos;
        bit         left;
        logic [3:0] exp_rows;

        reset   = 1'b1;
        pressed = 16'h0000;
        tick(3);
        chk("reset rows", rows === 4'b1110, rows, 4'b1110);
        chk("reset key_valid", key_valid === 1'b0, key_valid, 1'b0);
        chk("reset key_code", key_code === 4'h0, key_code, 4'h0);
        check_digits("reset");
        reset = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            exp_rows = 4'b0001 << ((k / 4) % 4);
            exp_rows = ~exp_rows;
            chk("idle scan rows", rows === exp_rows, rows, exp_rows);
        end
        chk("idle no pulse", pulses === 0, pulses, 0);

        pressed[key_pos(4'h6)] = 1'b1;
        wait_accept("key6", 4'h6);
        p = pulses;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (i % 15 == 0) chk("key6 rows frozen", rows === 4'b1101, rows, 4'b1101);
        end
        chk("key6 single pulse", pulses === p, pulses, p);
        pressed = 16'h0000;
        tick(9);
        chk("key6 rows frozen after release", rows === 4'b1101, rows, 4'b1101);
        left = 1'b0;
        n = 0;
        while (!left && n < 6) begin
            @(negedge clk);
            n++;
            left = (rows !== 4'b1101);
        end
        chk("key6 scan resumes", left === 1'b1, left, 1'b1);
        tick(SETTLE);

        pressed[key_pos(4'h5)] = 1'b1;
        wait_accept("key5", 4'h5);
        pressed = 16'h0000;
        tick(SETTLE);
        pressed[key_pos(4'hD)] = 1'b1;
        wait_accept("keyD", 4'hD);
        chk("keyD digit_old is 5", digit_old === 4'h5, digit_old, 4'h5);
        chk("keyD digit_new is D", digit_new === 4'hD, digit_new, 4'hD);
        pressed = 16'h0000;
        tick(SETTLE);

        n = 0;
        while (rows !== 4'b1110 && n < 20) begin
            @(negedge clk);
            n++;
        end
        pressed[key_pos(4'h8)] = 1'b1;
        n = 0;
        p = 0;
        while (p < 5 && n < 40) begin
            @(negedge clk);
            n++;
            p = (rows === 4'b1011) ? p + 1 : 0;
        end
        chk("key8 debounce entered", p === 5, p, 5);
        tick(3);
        p = pulses;
        pressed = 16'h0000;
        tick(3);
        pressed[key_pos(4'h8)] = 1'b1;
        tick(2);
        chk("key8 bounce no pulse", pulses === p, pulses, p);
        wait_accept("key8", 4'h8);
        p = pulses;
        pressed = 16'h0000;
        tick(3);
        pressed[key_pos(4'h8)] = 1'b1;
        tick(2);
        pressed = 16'h0000;
        tick(SETTLE + 4);
        chk("key8 release glitch no pulse", pulses === p, pulses, p);

        p = pulses;
        pressed[key_pos(4'h1)] = 1'b1;
        pressed[key_pos(4'h2)] = 1'b1;
        tick(60);
        chk("dual key rejected", pulses === p, pulses, p);
        pressed[key_pos(4'h2)] = 1'b0;
        wait_accept("key1", 4'h1);
        pressed = 16'h0000;
        tick(SETTLE);

        pressed[key_pos(4'hA)] = 1'b1;
        wait_accept("keyA", 4'hA);
        tick(5);
        reset = 1'b1;
        @(negedge clk);
        chk("held reset rows", rows === 4'b1110, rows, 4'b1110);
        chk("held reset key_valid", key_valid === 1'b0, key_valid, 1'b0);
        chk("held reset key_code", key_code === 4'h0, key_code, 4'h0);
        accepted.delete();
        check_digits("held reset");
        reset = 1'b0;
        wait_accept("keyA again", 4'hA);
        pressed = 16'h0000;
        tick(SETTLE);

        for (int t = 0; t < 12; t++) begin
            pos = int'($urandom_range(0, 15));
            tick(int'($urandom_range(0, 7)));
            pressed[pos] = 1'b1;
            wait_accept("random", KEYMAP[pos]);
            p = pulses;
            tick(int'($urandom_range(0, 20)));
            chk("random single pulse", pulses === p, pulses, p);
            pressed = 16'h0000;
            tick(SETTLE + int'($urandom_range(0, 5)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
